// File: rtl/mac_rx_chk_pkg.sv
// mac_rx_chk_pkg
//   Shared definitions for the MAC RX frame checker: FSM state encoding,
//   frame-length counter width and default legal length bounds.
package mac_rx_chk_pkg;

    localparam int LEN_W       = 16;    // frame length counter width
    localparam int DEF_MIN_LEN = 64;    // default minimum legal frame length
    localparam int DEF_MAX_LEN = 1518;  // default maximum legal frame length

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

endpackage

// File: rtl/mac_rx_checker_sat_cnt.sv
// sat_cnt
//   Saturating statistics counter with synchronous clear. Each cycle it can
//   add 1 (inc_i) and/or a value (add_i/add_val_i); the result sticks at
//   all-ones instead of wrapping.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_i           synchronous clear, wins over inc_i/add_i
//   inc_i           add one
//   add_i           add add_val_i
//   add_val_i       VAL_W-bit addend
//   cnt_o           W-bit counter value
module sat_cnt #(
    parameter int W     = 32,
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             add_i,
    input  logic [VAL_W-1:0] add_val_i,
    output logic [W-1:0]     cnt_o
);

    // Two guard bits: cnt + 1 + val can never overflow the sum width.
    localparam int SW = ((W > VAL_W) ? W : VAL_W) + 2;
    localparam logic [SW-1:0] MAX = {{(SW-W){1'b0}}, {W{1'b1}}};

    logic [W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0] sum;

    always_comb begin
        sum   = SW'(cnt_q) + SW'(inc_i) + (add_i ? SW'(add_val_i) : '0);
        cnt_d = (sum > MAX) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i || add_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_rx_checker.sv
// mac_rx_checker
//   Watches the MAC RX byte stream, tracks frame boundaries and keeps
//   saturating statistics: good/bad frames, bytes, framing protocol errors
//   and (optionally) length errors.
//   Optional feature: define MAC_RX_CHECKER_LEN_CHECK_EN to mark frames
//   shorter than MIN_LEN or longer than MAX_LEN as bad and count them in
//   len_err_cnt. Without it len_err_cnt is tied to zero.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rx_data/valid/sof/eof           MAC RX byte stream
//   rx_fr_good                      frame-good status, sampled on eof beat
//   rx_fr_err                       error strobe, any cycle
//   clr_stat                        clear counters and last_len
//   good_cnt, bad_cnt, byte_cnt     frame statistics (CNT_W bits)
//   proto_err_cnt, len_err_cnt      error statistics (CNT_W bits)
//   last_len                        length of last completed frame
//   err_pulse                       one-cycle strobe per bad frame/protocol error
module mac_rx_checker
    import mac_rx_chk_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    input  logic             rx_fr_good,
    input  logic             rx_fr_err,
    input  logic             clr_stat,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] proto_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [LEN_W-1:0] last_len,
    output logic             err_pulse
);

`ifdef MAC_RX_CHECKER_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic             err_seen_q, err_seen_d;   // rx_fr_err seen in open frame
    logic             orphan_q, orphan_d;       // inside a run of sof-less beats in IDLE
    logic             err_pulse_q, err_pulse_d;
    logic [LEN_W-1:0] last_len_q, last_len_d;

    logic             close;                    // a frame completes this beat
    logic [LEN_W-1:0] close_len;
    logic             close_err;
    logic             proto_err;
    logic             len_bad, frame_ok, good_ev, bad_ev;

    // Payload bytes are not inspected; only framing is checked.
    logic data_unused;
    assign data_unused = ^rx_data;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        err_seen_d = err_seen_q;
        orphan_d   = 1'b0;
        close      = 1'b0;
        close_len  = len_q;
        close_err  = 1'b0;
        proto_err  = 1'b0;
        len_inc    = (&len_q) ? len_q : len_q + ONE;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_sof && rx_eof) begin
                        close     = 1'b1;
                        close_len = ONE;
                        close_err = rx_fr_err;
                    end else if (rx_sof) begin
                        state_d    = ST_IN_FRAME;
                        len_d      = ONE;
                        err_seen_d = rx_fr_err;
                    end else begin
                        // Count only the first beat of a contiguous orphan run.
                        orphan_d  = 1'b1;
                        proto_err = ~orphan_q;
                    end
                end
            end
            ST_IN_FRAME: begin
                if (rx_valid && rx_sof) begin
                    // Restart: the open frame is dropped uncounted.
                    proto_err = 1'b1;
                    if (rx_eof) begin
                        close     = 1'b1;
                        close_len = ONE;
                        close_err = rx_fr_err;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d      = ONE;
                        err_seen_d = rx_fr_err;
                    end
                end else if (rx_valid && rx_eof) begin
                    close     = 1'b1;
                    close_len = len_inc;
                    close_err = err_seen_q | rx_fr_err;
                    state_d   = ST_IDLE;
                end else begin
                    if (rx_valid) begin
                        len_d = len_inc;
                    end
                    err_seen_d = err_seen_q | rx_fr_err;
                end
            end
        endcase

        len_bad     = LEN_CHK && ((close_len < MIN_L) || (close_len > MAX_L));
        frame_ok    = rx_fr_good & ~close_err & ~len_bad;
        good_ev     = close & frame_ok;
        bad_ev      = close & ~frame_ok;
        err_pulse_d = bad_ev | proto_err;
        last_len_d  = clr_stat ? '0 : (close ? close_len : last_len_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            err_seen_q  <= 1'b0;
            orphan_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            last_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            err_seen_q  <= err_seen_d;
            orphan_q    <= orphan_d;
            err_pulse_q <= err_pulse_d;
            last_len_q  <= last_len_d;
        end
    end

    sat_cnt #(.W(CNT_W), .VAL_W(1)) u_good (
        .clk(clk), .rst(rst), .clr_i(clr_stat), .inc_i(good_ev),
        .add_i(1'b0), .add_val_i(1'b0), .cnt_o(good_cnt)
    );

    sat_cnt #(.W(CNT_W), .VAL_W(1)) u_bad (
        .clk(clk), .rst(rst), .clr_i(clr_stat), .inc_i(bad_ev),
        .add_i(1'b0), .add_val_i(1'b0), .cnt_o(bad_cnt)
    );

    sat_cnt #(.W(CNT_W), .VAL_W(LEN_W)) u_byte (
        .clk(clk), .rst(rst), .clr_i(clr_stat), .inc_i(1'b0),
        .add_i(close), .add_val_i(close_len), .cnt_o(byte_cnt)
    );

    sat_cnt #(.W(CNT_W), .VAL_W(1)) u_proto (
        .clk(clk), .rst(rst), .clr_i(clr_stat), .inc_i(proto_err),
        .add_i(1'b0), .add_val_i(1'b0), .cnt_o(proto_err_cnt)
    );

`ifdef MAC_RX_CHECKER_LEN_CHECK_EN
    sat_cnt #(.W(CNT_W), .VAL_W(1)) u_len_err (
        .clk(clk), .rst(rst), .clr_i(clr_stat), .inc_i(close & len_bad),
        .add_i(1'b0), .add_val_i(1'b0), .cnt_o(len_err_cnt)
    );
`else
    assign len_err_cnt = '0;
`endif

    assign last_len  = last_len_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_mac_rx_checker.sv
// tb_mac_rx_checker
//   Directed bench: a table of single-frame vectors plus hand-written
//   sequences for restarts, orphan runs, reset, clear and saturation.
module tb_mac_rx_checker;

`ifdef MAC_RX_CHECKER_LEN_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx_valid, rx_sof, rx_eof, rx_fr_good, rx_fr_err, clr_stat;
    logic [7:0]  rx_data;
    logic [31:0] good_cnt, bad_cnt, byte_cnt, proto_err_cnt, len_err_cnt;
    logic [15:0] last_len, ll4;
    logic        err_pulse, ep4;
    logic [3:0]  g4, b4, by4, p4, l4;

    int checks = 0;
    int failures = 0;
    int pulse_n = 0;

    mac_rx_checker dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_fr_good(rx_fr_good),
        .rx_fr_err(rx_fr_err), .clr_stat(clr_stat),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt), .byte_cnt(byte_cnt),
        .proto_err_cnt(proto_err_cnt), .len_err_cnt(len_err_cnt),
        .last_len(last_len), .err_pulse(err_pulse)
    );

    // Narrow-counter instance; MIN_LEN=1 keeps short frames legal in every build.
    mac_rx_checker #(.CNT_W(4), .MIN_LEN(1), .MAX_LEN(1518)) dut4 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_fr_good(rx_fr_good),
        .rx_fr_err(rx_fr_err), .clr_stat(clr_stat),
        .good_cnt(g4), .bad_cnt(b4), .byte_cnt(by4),
        .proto_err_cnt(p4), .len_err_cnt(l4),
        .last_len(ll4), .err_pulse(ep4)
    );

    always @(negedge clk) if (err_pulse === 1'b1) pulse_n++;

    typedef struct {
        int len;
        int err_at;      // 1-based byte carrying rx_fr_err, 0 = none
        bit good;        // rx_fr_good on eof
        int exp_good;
        int exp_bad;
        int exp_len_err;
        int exp_pulses;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_cnts(input string t, input int g, input int b, input int by,
                            input int pr, input int le, input int ll);
        chk({t, ".good"},  good_cnt,      g);
        chk({t, ".bad"},   bad_cnt,       b);
        chk({t, ".bytes"}, byte_cnt,      by);
        chk({t, ".proto"}, proto_err_cnt, pr);
        chk({t, ".lenerr"}, len_err_cnt,  le);
        chk({t, ".last"},  {16'd0, last_len}, ll);
    endtask

    task automatic beat(input bit v, input bit s, input bit e, input bit g, input bit er);
        @(negedge clk);
        rx_valid   = v;
        rx_sof     = s;
        rx_eof     = e;
        rx_fr_good = g;
        rx_fr_err  = er;
        rx_data    = rx_data + 8'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Ends at the edge after eof has been sampled: counters are updated.
    task automatic send_frame(input int len, input int err_at, input bit good);
        for (int i = 1; i <= len; i++)
            beat(1'b1, i == 1, i == len, (i == len) && good, i == err_at);
        idle(1);
    endtask

    task automatic open_frame(input int n);
        for (int i = 1; i <= n; i++) beat(1'b1, i == 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_frame(input int n, input bit good);
        for (int i = 1; i <= n; i++) beat(1'b1, 1'b0, i == n, (i == n) && good, 1'b0);
        idle(1);
    endtask

    task automatic clear();
        idle(1);
        clr_stat = 1'b1;
        idle(1);
        clr_stat = 1'b0;
    endtask

    initial begin
        int p0;
        tbl[0] = '{64,   0,  1'b1, 1,         0,         0,  0};
        tbl[1] = '{100,  50, 1'b1, 0,         1,         0,  1};
        tbl[2] = '{1,    0,  1'b1, LC ? 0 : 1, LC ? 1 : 0, LC ? 1 : 0, LC ? 1 : 0};
        tbl[3] = '{70,   0,  1'b0, 0,         1,         0,  1};
        tbl[4] = '{40,   0,  1'b1, LC ? 0 : 1, LC ? 1 : 0, LC ? 1 : 0, LC ? 1 : 0};
        tbl[5] = '{1600, 0,  1'b1, LC ? 0 : 1, LC ? 1 : 0, LC ? 1 : 0, LC ? 1 : 0};
        tbl[6] = '{10,   1,  1'b1, 0,         1,         LC ? 1 : 0, 1};

        rst = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        rx_fr_good = 1'b0; rx_fr_err = 1'b0; clr_stat = 1'b0; rx_data = 8'd0;
        repeat (3) @(negedge clk);
        chk_cnts("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.pulse", {31'd0, err_pulse}, 0);
        chk("reset.good4", {28'd0, g4}, 0);

        // First beat right as reset releases: a 1-byte frame.
        rst = 1'b0; rx_valid = 1'b1; rx_sof = 1'b1; rx_eof = 1'b1; rx_fr_good = 1'b1;
        idle(1);
        chk("first.pulse", {31'd0, err_pulse}, LC);
        chk_cnts("first", LC ? 0 : 1, LC ? 1 : 0, 1, 0, LC ? 1 : 0, 1);

        // Reset in the middle of a frame drops it.
        clear();
        open_frame(10);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send_frame(64, 0, 1'b1);
        chk_cnts("rstmid", 1, 0, 64, 0, 0, 64);

        for (int r = 0; r < 7; r++) begin
            clear();
            p0 = pulse_n;
            send_frame(tbl[r].len, tbl[r].err_at, tbl[r].good);
            chk($sformatf("row%0d.pulse_now", r), {31'd0, err_pulse}, (tbl[r].exp_pulses != 0));
            idle(2);
            chk_cnts($sformatf("row%0d", r), tbl[r].exp_good, tbl[r].exp_bad,
                     tbl[r].len, 0, tbl[r].exp_len_err, tbl[r].len);
            chk($sformatf("row%0d.pulses", r), pulse_n - p0, tbl[r].exp_pulses);
        end

        // sof at byte 10 of an open frame restarts into a 64-byte good frame.
        clear();
        p0 = pulse_n;
        open_frame(9);
        send_frame(64, 0, 1'b1);
        idle(1);
        chk_cnts("sofmid", 1, 0, 64, 1, 0, 64);
        chk("sofmid.pulses", pulse_n - p0, 1);

        // Orphan beats: one run of 3, a gap, one more.
        clear();
        p0 = pulse_n;
        repeat (3) beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk_cnts("orphan", 0, 0, 0, 2, 0, 0);
        chk("orphan.pulses", pulse_n - p0, 2);

        // Bad 1-byte frame then an orphan beat back to back: two pulses.
        clear();
        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b.pulse1", {31'd0, err_pulse}, 1);
        idle(1);
        chk("b2b.pulse2", {31'd0, err_pulse}, 1);
        idle(1);
        chk("b2b.pulse3", {31'd0, err_pulse}, 0);
        chk_cnts("b2b", 0, 1, 1, 1, LC ? 1 : 0, 1);

        // sof+eof inside an open frame closes a 1-byte frame and returns to IDLE.
        clear();
        open_frame(5);
        beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk_cnts("sofeof", LC ? 0 : 1, LC ? 1 : 0, 1, 2, LC ? 1 : 0, 1);

        // fr_err in IDLE ignored; fr_err on a non-valid cycle inside a frame counts.
        clear();
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(64, 0, 1'b1);
        open_frame(10);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_frame(54, 1'b1);
        idle(1);
        chk_cnts("frerr", 1, 1, 128, 0, 0, 64);

        // sof/eof without valid are ignored.
        clear();
        beat(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(64, 0, 1'b1);
        chk_cnts("novalid", 1, 0, 64, 0, 0, 64);

        // Clear mid-frame keeps the open frame; clear on eof beat wins.
        clear();
        open_frame(5);
        clear();
        finish_frame(59, 1'b1);
        chk_cnts("clrmid", 1, 0, 64, 0, 0, 64);
        open_frame(63);
        beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        clr_stat = 1'b1;
        idle(1);
        clr_stat = 1'b0;
        idle(1);
        chk_cnts("clrprio", 0, 0, 0, 0, 0, 0);

        // 4-bit counters saturate; clear on eof+1 of a 17th frame.
        clear();
        for (int k = 0; k < 16; k++) send_frame(2, 0, 1'b1);
        chk("sat.good4", {28'd0, g4}, 15);
        chk("sat.bytes4", {28'd0, by4}, 15);
        chk("sat.bad4", {28'd0, b4}, 0);
        chk("sat.last4", {16'd0, ll4}, 2);
        chk("sat.good32", good_cnt, LC ? 0 : 16);
        send_frame(2, 0, 1'b1);
        clr_stat = 1'b1;
        idle(1);
        clr_stat = 1'b0;
        idle(1);
        chk("satclr.good4", {28'd0, g4}, 0);
        chk("satclr.bytes4", {28'd0, by4}, 0);
        chk("satclr.last4", {16'd0, ll4}, 0);
        chk("satclr.good32", good_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_rx_checker.md
MAC_RX_CHECKER -- requirements
Module: mac_rx_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every statistics counter.
REQ-002 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes, used only with the length check.
REQ-003 SHALL have parameter MAX_LEN, default 1518, maximum legal frame length in bytes, used only with the length check.
REQ-004 SHALL have ports:
- clk  in  1  the single clock (mac_gtx_clk domain).
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  MAC RX byte.
- rx_valid  in  1  byte qualifier.
- rx_sof  in  1  first byte of frame; valid only with rx_valid.
- rx_eof  in  1  last byte of frame; valid only with rx_valid.
- rx_fr_good  in  1  MAC frame-good status; sampled on the eof beat.
- rx_fr_err  in  1  MAC error strobe; may assert on any cycle.
- clr_stat  in  1  synchronous clear of all counters.
- good_cnt  out  CNT_W  good frames.
- bad_cnt  out  CNT_W  bad frames.
- byte_cnt  out  CNT_W  bytes in completed frames, good or bad.
- proto_err_cnt  out  CNT_W  framing protocol violations.
- len_err_cnt  out  CNT_W  length violations.
- last_len  out  16  length of the most recent completed frame.
- err_pulse  out  1  one-cycle strobe for any bad frame or protocol error.
REQ-005 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 SHALL implement a two-state FSM: IDLE and IN_FRAME.
REQ-007 IDLE: rx_valid&rx_sof&~rx_eof SHALL go to IN_FRAME with the length count set to 1.
REQ-008 IN_FRAME: each rx_valid beat SHALL increment the 16-bit length count, saturating at 0xFFFF.
REQ-009 rx_valid&rx_eof in IN_FRAME SHALL close the frame and return to IDLE.
REQ-010 rx_valid&rx_sof&rx_eof in IDLE SHALL be a complete 1-byte frame; the FSM stays in IDLE.
REQ-011 On close, the frame SHALL be good iff rx_fr_good=1 on the eof beat and no rx_fr_err was seen from sof through eof inclusive; otherwise it SHALL be bad.
REQ-012 good_cnt or bad_cnt (exactly one), byte_cnt (+frame length) and last_len SHALL update on the cycle after the eof beat.
REQ-013 rx_sof in IN_FRAME SHALL: increment proto_err_cnt; discard the open frame without counting it; restart the length count at 1; keep the FSM in IN_FRAME, or return it to IDLE if rx_eof is also set and that 1-byte frame is closed.
REQ-014 rx_valid without rx_sof in IDLE SHALL increment proto_err_cnt once per contiguous run of such beats; those bytes SHALL be ignored.
REQ-015 rx_sof or rx_eof without rx_valid SHALL be ignored.
REQ-016 rx_fr_err in IDLE SHALL be ignored.
REQ-017 All counters SHALL saturate at all-ones and never wrap.
REQ-018 byte_cnt addition SHALL saturate if the sum would overflow.
REQ-019 clr_stat SHALL zero all counters and last_len on the next edge and SHALL take priority over a same-cycle increment.
REQ-020 clr_stat SHALL NOT affect FSM state or the open frame.
REQ-021 err_pulse SHALL assert for exactly one cycle, together with the counter update, for each bad frame or protocol error.
REQ-022 Two events in consecutive cycles SHALL produce two pulses.

Reset
REQ-023 rst SHALL force: FSM to IDLE; length count, all counters and last_len to 0; err_pulse to 0.
REQ-024 rst during IN_FRAME SHALL drop the open frame without counting it.
REQ-025 After reset, the first beat SHALL be accepted on the following cycle.

Configuration
REQ-026 With macro MAC_RX_CHECKER_LEN_CHECK_EN defined, a closed frame with length <MIN_LEN or >MAX_LEN SHALL increment len_err_cnt and SHALL be counted as bad, even if rx_fr_good=1.
REQ-027 Without MAC_RX_CHECKER_LEN_CHECK_EN, len_err_cnt SHALL be constant 0, length SHALL NOT affect the good/bad decision, and the port list SHALL be unchanged.

Structure
REQ-028 Package mac_rx_chk_pkg SHALL hold the FSM state enum, the default MIN_LEN/MAX_LEN constants, and the 16-bit length width constant.
REQ-029 A sub-module sat_cnt (saturating counter with synchronous clear, increment and add-value) SHALL be instantiated once per statistic.

Verification
REQ-030 Bench SHALL cover: 64-byte frame, fr_good=1 at eof -> good_cnt=1, byte_cnt=64, last_len=64, err_pulse=0.
REQ-031 Bench SHALL cover: 100-byte frame with a rx_fr_err pulse at byte 50 and fr_good=1 -> bad_cnt=1, good_cnt=0, one err_pulse.
REQ-032 Bench SHALL cover: sof at byte 10 of an open frame, then a 64-byte good frame -> proto_err_cnt=1, good_cnt=1, byte_cnt=64.
REQ-033 Bench SHALL cover: 3 valid beats without sof in IDLE, then 1 more valid beat without sof after a gap -> proto_err_cnt=2.
REQ-034 Bench SHALL cover: with the macro, a 40-byte good frame and a 1600-byte good frame -> len_err_cnt=2, bad_cnt=2; without the macro -> good_cnt=2, len_err_cnt=0.
REQ-035 Bench SHALL cover: CNT_W=4, 16 good frames -> good_cnt=15 (saturated); clr_stat on the eof+1 cycle of a 17th frame -> good_cnt=0.
